// File: rtl/eth_rx_multiwidth.sv
// eth_rx_multiwidth: post-SFD Ethernet frame receiver for 2/4/8-bit PHY symbols.
// Packs LSB-first symbols into bytes, runs the reflected CRC-32 over the whole
// frame, checks destination MAC, length and alignment, and streams the payload
// with the 4-byte FCS stripped by a 4-entry holdback buffer.
// Optional build macro: ETH_RX_STATS_EN adds saturating good/err/filtered counters.
//
// Handshake: inclk is a frame-long valid with no back-pressure (high for every
// symbol of a frame, low between frames); outclk, ethertype_outclk and done are
// single-cycle strobes with no ready - the consumer must take the data on the strobe.
module eth_rx_multiwidth #(
  parameter int IN_WIDTH  = 2,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inclk,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic [47:0]          local_mac,
  output logic                 outclk,
  output logic [7:0]           out,
  output logic                 ethertype_outclk,
  output logic [15:0]          ethertype_out,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic                 filtered,
  output logic [2:0]           dbg_state
`ifdef ETH_RX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] rx_good_cnt,
  output logic [CNT_WIDTH-1:0] rx_err_cnt,
  output logic [CNT_WIDTH-1:0] rx_filt_cnt
`endif
);

  localparam int SYMS = 8 / IN_WIDTH;
  localparam logic [2:0] LAST_PHASE = 3'(SYMS - 1);
  localparam int CW = $clog2(MAX_FRAME + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_FRAME + 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_FRAME);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_BODY = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_STAT = 3'd4;

  logic [2:0]    state;
  logic [2:0]    phase;
  logic [31:0]   crc;
  logic [CW-1:0] cnt;
  logic [7:0]    sr;
  logic [47:0]   mac_q;
  logic          m_local;
  logic          m_bcast;
  logic [7:0]    eth_hi;
  logic [7:0]    hb [4];
  logic [2:0]    hb_cnt;

  // Working values: in IDLE the first symbol is processed against fresh frame state.
  logic          fresh;
  logic [2:0]    phase_b;
  logic [31:0]   crc_b;
  logic [CW-1:0] cnt_b;
  logic [47:0]   mac_b;
  logic          mloc_b;
  logic          mbc_b;
  logic          byte_done;
  logic [7:0]    byte_nxt;
  logic [CW-1:0] cnt_inc;
  logic          is_dst;
  logic [2:0]    hdr_idx;
  logic [7:0]    mac_byte;
  logic          mloc_n;
  logic          mbc_n;
  logic [31:0]   crc_n;
  logic [2:0]    end_code;

  assign dbg_state = state;

  // Bit-serial reflected CRC-32 over one symbol, earliest bit first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [IN_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < IN_WIDTH; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  // Symbol packing, CRC, header compare and end-of-frame status decode.
  always_comb begin
    fresh     = (state == S_IDLE);
    phase_b   = fresh ? 3'd0 : phase;
    crc_b     = fresh ? 32'hFFFFFFFF : crc;
    cnt_b     = fresh ? '0 : cnt;
    mac_b     = fresh ? local_mac : mac_q;
    mloc_b    = fresh | m_local;
    mbc_b     = fresh | m_bcast;
    byte_done = (phase_b == LAST_PHASE);
    byte_nxt  = 8'({in, sr} >> IN_WIDTH);
    cnt_inc   = (cnt_b == CNT_SAT) ? cnt_b : cnt_b + 1'b1;
    is_dst    = (cnt_b < CW'(6));
    hdr_idx   = cnt_b[2:0];
    mac_byte  = 8'h00;
    case (hdr_idx)
      3'd0:    mac_byte = mac_b[47:40];
      3'd1:    mac_byte = mac_b[39:32];
      3'd2:    mac_byte = mac_b[31:24];
      3'd3:    mac_byte = mac_b[23:16];
      3'd4:    mac_byte = mac_b[15:8];
      3'd5:    mac_byte = mac_b[7:0];
      default: mac_byte = 8'h00;
    endcase
    mloc_n = mloc_b & (byte_nxt == mac_byte);
    mbc_n  = mbc_b & (byte_nxt == 8'hFF);
    crc_n  = crc_upd(crc_b, in);
    if (phase != 3'd0)            end_code = 3'd4;
    else if (cnt == CNT_SAT)      end_code = 3'd3;
    else if (cnt < CNT_MIN)       end_code = 3'd2;
    else if (crc != CRC_RESIDUE)  end_code = 3'd1;
    else                          end_code = 3'd0;
  end

  // Frame FSM, byte counting, holdback buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      phase            <= '0;
      crc              <= 32'hFFFFFFFF;
      cnt              <= '0;
      sr               <= '0;
      mac_q            <= '0;
      m_local          <= 1'b0;
      m_bcast          <= 1'b0;
      eth_hi           <= '0;
      hb_cnt           <= '0;
      for (int i = 0; i < 4; i++) hb[i] <= '0;
      outclk           <= 1'b0;
      out              <= '0;
      ethertype_outclk <= 1'b0;
      ethertype_out    <= '0;
      done             <= 1'b0;
      err              <= 1'b0;
      err_code         <= '0;
      filtered         <= 1'b0;
    end else begin
      outclk           <= 1'b0;
      ethertype_outclk <= 1'b0;
      done             <= 1'b0;
      // Frame start; a symbol arriving during STAT opens the frame but is itself lost.
      if (inclk && (state == S_IDLE || state == S_STAT)) begin
        state    <= S_HDR;
        phase    <= '0;
        crc      <= 32'hFFFFFFFF;
        cnt      <= '0;
        mac_q    <= local_mac;
        m_local  <= 1'b1;
        m_bcast  <= 1'b1;
        hb_cnt   <= '0;
        err      <= 1'b0;
        err_code <= '0;
        filtered <= 1'b0;
      end
      if (inclk && state != S_STAT) begin
        phase <= byte_done ? 3'd0 : phase_b + 3'd1;
        crc   <= crc_n;
        sr    <= byte_nxt;
        if (byte_done) begin
          cnt <= cnt_inc;
          if (fresh || state == S_HDR) begin
            if (is_dst) begin
              m_local <= mloc_n;
              m_bcast <= mbc_n;
            end
            if (cnt_b == CW'(5) && !mloc_n && !mbc_n) filtered <= 1'b1;
            if (cnt_b == CW'(12)) eth_hi <= byte_nxt;
            if (cnt_b == CW'(13)) begin
              ethertype_out    <= {eth_hi, byte_nxt};
              ethertype_outclk <= 1'b1;
              state            <= filtered ? S_DROP : S_BODY;
            end
          end else if (state == S_BODY) begin
            if (cnt_inc == CNT_SAT) begin
              state <= S_DROP;
            end else if (hb_cnt == 3'd4) begin
              out    <= hb[0];
              outclk <= 1'b1;
              hb[0]  <= hb[1];
              hb[1]  <= hb[2];
              hb[2]  <= hb[3];
              hb[3]  <= byte_nxt;
            end else begin
              hb[hb_cnt[1:0]] <= byte_nxt;
              hb_cnt          <= hb_cnt + 3'd1;
            end
          end
        end
      end else if (!inclk && (state == S_HDR || state == S_BODY || state == S_DROP)) begin
        state    <= S_STAT;
        done     <= 1'b1;
        err      <= (end_code != 3'd0);
        err_code <= end_code;
        hb_cnt   <= '0;
      end else if (state == S_STAT && !inclk) begin
        state <= S_IDLE;
      end
    end
  end

`ifdef ETH_RX_STATS_EN
  // Saturating per-frame counters, classified on the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_good_cnt <= '0;
      rx_err_cnt  <= '0;
      rx_filt_cnt <= '0;
    end else if (done) begin
      if (err) begin
        if (rx_err_cnt != '1) rx_err_cnt <= rx_err_cnt + 1'b1;
      end else if (filtered) begin
        if (rx_filt_cnt != '1) rx_filt_cnt <= rx_filt_cnt + 1'b1;
      end else begin
        if (rx_good_cnt != '1) rx_good_cnt <= rx_good_cnt + 1'b1;
      end
    end
  end
`else
  // Counter width only matters when the statistics counters are built.
  if (CNT_WIDTH < 1) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_eth_rx_multiwidth.sv
// tb_eth_rx_multiwidth: directed frames into a 2-bit and a 4-bit receiver.
// Frames (with FCS) are built here; expected payload, status and ethertype
// come from the frame tables below.
module tb_eth_rx_multiwidth;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        inclk2, inclk4;
  logic [1:0]  in2;
  logic [3:0]  in4;
  logic [47:0] local_mac;
  logic        outclk2, outclk4, eto2, eto4;
  logic [7:0]  out2, out4;
  logic [15:0] et2, et4;
  logic        done2, done4, err2, err4, filt2, filt4;
  logic [2:0]  code2, code4, dbg2, dbg4;
`ifdef ETH_RX_STATS_EN
  logic [15:0] good2, errc2, filtc2, good4, errc4, filtc4;
`endif

  eth_rx_multiwidth #(.IN_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .inclk(inclk2), .in(in2), .local_mac(local_mac),
    .outclk(outclk2), .out(out2), .ethertype_outclk(eto2), .ethertype_out(et2),
    .done(done2), .err(err2), .err_code(code2), .filtered(filt2), .dbg_state(dbg2)
`ifdef ETH_RX_STATS_EN
    , .rx_good_cnt(good2), .rx_err_cnt(errc2), .rx_filt_cnt(filtc2)
`endif
  );

  eth_rx_multiwidth #(.IN_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .inclk(inclk4), .in(in4), .local_mac(local_mac),
    .outclk(outclk4), .out(out4), .ethertype_outclk(eto4), .ethertype_out(et4),
    .done(done4), .err(err4), .err_code(code4), .filtered(filt4), .dbg_state(dbg4)
`ifdef ETH_RX_STATS_EN
    , .rx_good_cnt(good4), .rx_err_cnt(errc4), .rx_filt_cnt(filtc4)
`endif
  );

  // ---------------- vectors / scoreboard state ----------------
  typedef struct {
    int         sel;    // 0: IN_WIDTH=2 receiver, 1: IN_WIDTH=4 receiver
    int         len;    // bytes dst..FCS
    int         dst;    // 0 local, 1 broadcast, 2 foreign
    int         flip;   // byte index to corrupt after FCS, -1 none
    int         extra;  // trailing symbols beyond the last byte
    logic [2:0] code;
    logic       filt;
    int         npay;   // expected outclk bytes
  } vec_t;

  vec_t        vecs [10];
  logic [7:0]  frm [0:1699];
  logic [7:0]  exp_q [$];
  logic [7:0]  cap2_q [$];
  logic [7:0]  cap4_q [$];
  int          done_cnt [2];
  logic        d_err [2];
  logic [2:0]  d_code [2];
  logic        d_filt [2];
  int          eth_cnt [2];
  logic [15:0] eth_val [2];
  int          checks;
  int          errors;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (outclk2) cap2_q.push_back(out2);
    if (outclk4) cap4_q.push_back(out4);
    if (done2) begin done_cnt[0]++; d_err[0] = err2; d_code[0] = code2; d_filt[0] = filt2; end
    if (done4) begin done_cnt[1]++; d_err[1] = err4; d_code[1] = code4; d_filt[1] = filt4; end
    if (eto2) begin eth_cnt[0]++; eth_val[0] = et2; end
    if (eto4) begin eth_cnt[1]++; eth_val[1] = et4; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int len, input int dst, input int flip);
    logic [47:0] d;
    logic [47:0] s;
    logic [31:0] c;
    case (dst)
      0:       d = local_mac;
      1:       d = 48'hFFFFFFFFFFFF;
      default: d = 48'h020000000099;
    endcase
    s = 48'h021122334455;
    for (int i = 0; i < 6; i++) begin
      frm[i]     = d[8*(5-i) +: 8];
      frm[6 + i] = s[8*(5-i) +: 8];
    end
    frm[12] = 8'h08;
    frm[13] = 8'h00;
    for (int i = 14; i < len - 4; i++) frm[i] = 8'(i * 37 + len);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) c = crc_byte(c, frm[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) frm[len - 4 + k] = c[8*k +: 8];
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h08;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sym(input int sel, input logic [7:0] v);
    if (sel == 0) begin inclk2 = 1'b1; in2 = v[1:0]; end
    else          begin inclk4 = 1'b1; in4 = v[3:0]; end
  endtask

  // Sends frm[0..len-1]; abort_at >= 0 pulses rst instead of sending that byte.
  task automatic send(input int sel, input int len, input int extra, input int abort_at);
    int w;
    w = (sel == 0) ? 2 : 4;
    for (int b = 0; b < len; b++) begin
      if (b == abort_at) begin
        @(negedge clk); rst = 1'b1; inclk2 = 1'b0; inclk4 = 1'b0;
        @(negedge clk); rst = 1'b0;
        return;
      end
      for (int s = 0; s < 8 / w; s++) begin
        @(negedge clk);
        drive_sym(sel, frm[b] >> (s * w));
      end
    end
    for (int s = 0; s < extra; s++) begin
      @(negedge clk);
      drive_sym(sel, 8'h05);
    end
    @(negedge clk); inclk2 = 1'b0; inclk4 = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int d0, e0, base, n, bad;
    logic [7:0] got;
    logic cur_err;
`ifdef ETH_RX_STATS_EN
    logic [15:0] f0, f1;
`endif
    build_frame(v.len, v.dst, v.flip);
    exp_q.delete();
    for (int i = 0; i < v.npay; i++) exp_q.push_back(frm[14 + i]);
    d0   = done_cnt[v.sel];
    e0   = eth_cnt[v.sel];
    base = (v.sel == 0) ? cap2_q.size() : cap4_q.size();
`ifdef ETH_RX_STATS_EN
    f0 = (v.sel == 0) ? filtc2 : filtc4;
`endif
    send(v.sel, v.len, v.extra, -1);
    chk($sformatf("v%0d_early_done", id), done_cnt[v.sel] - d0, 0);
    for (int c = 0; c < 20 && done_cnt[v.sel] == d0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), done_cnt[v.sel] - d0, 1);
    chk($sformatf("v%0d_err", id), d_err[v.sel], (v.code != 3'd0));
    chk($sformatf("v%0d_err_code", id), d_code[v.sel], v.code);
    chk($sformatf("v%0d_filtered", id), d_filt[v.sel], v.filt);
    cur_err = (v.sel == 0) ? err2 : err4;
    chk($sformatf("v%0d_err_held", id), cur_err, (v.code != 3'd0));
    chk($sformatf("v%0d_etype_pulse", id), eth_cnt[v.sel] - e0, 1);
    chk($sformatf("v%0d_etype", id), eth_val[v.sel], 16'h0800);
    n = ((v.sel == 0) ? cap2_q.size() : cap4_q.size()) - base;
    chk($sformatf("v%0d_pay_count", id), n, v.npay);
    bad = 0;
    for (int i = 0; i < v.npay && i < n; i++) begin
      got = (v.sel == 0) ? cap2_q[base + i] : cap4_q[base + i];
      if (got !== exp_q[i]) bad++;
    end
    chk($sformatf("v%0d_pay_data_bad_bytes", id), bad, 0);
`ifdef ETH_RX_STATS_EN
    f1 = (v.sel == 0) ? filtc2 : filtc4;
    chk($sformatf("v%0d_filt_cnt_delta", id), f1 - f0, (v.filt && v.code == 3'd0) ? 1 : 0);
`endif
  endtask

  // Watchdog: a hung handshake still ends in a summary-visible failure.
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    checks = 0; errors = 0;
    for (int i = 0; i < 2; i++) begin done_cnt[i] = 0; eth_cnt[i] = 0; end
    local_mac = 48'h020000000001;
    rst = 1'b1; inclk2 = 1'b0; inclk4 = 1'b0; in2 = '0; in4 = '0;

    //            sel len   dst flip extra code  filt  npay
    vecs[0] = '{0,   64, 0,  -1, 0, 3'd0, 1'b0,   46};  // good, IN_WIDTH=2
    vecs[1] = '{0,   64, 0,  20, 0, 3'd1, 1'b0,   46};  // payload bit flipped
    vecs[2] = '{0,   40, 0,  -1, 0, 3'd2, 1'b0,   22};  // runt
    vecs[3] = '{0,   63, 0,  -1, 0, 3'd2, 1'b0,   45};  // one below minimum
    vecs[4] = '{0, 1600, 0,  -1, 0, 3'd3, 1'b0, 1500};  // giant
    vecs[5] = '{1,   64, 0,  -1, 1, 3'd4, 1'b0,   46};  // extra nibble
    vecs[6] = '{1,   64, 1,  -1, 0, 3'd0, 1'b0,   46};  // broadcast
    vecs[7] = '{1,   64, 2,  -1, 0, 3'd0, 1'b1,    0};  // foreign dst
    vecs[8] = '{1, 1518, 0,  -1, 0, 3'd0, 1'b0, 1500};  // exactly maximum
    vecs[9] = '{1, 1519, 0,  -1, 0, 3'd3, 1'b0, 1500};  // one above maximum

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state_w2", {outclk2, out2, eto2, et2, done2, err2, code2, filt2, dbg2}, 0);
    chk("reset_state_w4", {outclk4, out4, eto4, et4, done4, err4, code4, filt4, dbg4}, 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset in the middle of a frame: outputs clear at once, no done.
    build_frame(64, 0, -1);
    d0 = done_cnt[0];
    send(0, 64, 0, 30);
    chk("rst_mid_frame_outputs", {outclk2, out2, eto2, et2, done2, err2, code2, filt2, dbg2}, 0);
    repeat (6) @(negedge clk);
    chk("rst_mid_frame_no_done", done_cnt[0] - d0, 0);
    run_vec(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
